// File: rtl/strip_trigger_queue.sv
// Trigger request FIFO with duplicate/invalid filtering and a paced
// issue FSM that feeds strip_trigger_gen.
module strip_trigger_queue #(
   parameter int DEPTH   = 8,
   parameter int HOLDOFF = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load_in,
   input  logic [11:0] bcid_in,
   input  logic [7:0]  band_id_in,
   input  logic [4:0]  phi_id_in,
   input  logic        gen_ready,
   input  logic        clear_counters,
   output logic        load_out,
   output logic [11:0] bcid_out,
   output logic [7:0]  band_id_out,
   output logic [4:0]  phi_id_out,
   output logic [6:0]  fifo_level,
   output logic [15:0] drop_count,
   output logic [15:0] dup_count,
   output logic [15:0] inval_count
);

   localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] PTR_ONE = 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_WAIT  = 2'd3;

   logic [24:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [6:0]    r_level;
   logic [1:0]    r_state;
   logic [3:0]    r_hcnt;
   logic [19:0]   r_last;
   logic          r_last_vld;
   logic          r_load_out;
   logic [24:0]   r_out;
   logic [15:0]   r_drop;
   logic [15:0]   r_dup;
   logic [15:0]   r_inval;

   logic w_inval;
   logic w_dup;
   logic w_full;
   logic w_drop;
   logic w_push;
   logic w_pop;

   // Fullness is judged on the start-of-cycle level, before any pop.
   assign w_inval = load_in && (band_id_in == 8'hFF);
   assign w_dup   = load_in && !w_inval && r_last_vld &&
                    ({bcid_in, band_id_in} == r_last);
   assign w_full  = (r_level == 7'(DEPTH));
   assign w_drop  = load_in && !w_inval && !w_dup && w_full;
   assign w_push  = load_in && !w_inval && !w_dup && !w_full;
   assign w_pop   = (r_state == S_ISSUE);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {bcid_in, band_id_in, phi_id_in};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_last     <= '0;
         r_last_vld <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr   <= r_wr_ptr + PTR_ONE;
            r_last     <= {bcid_in, band_id_in};
            r_last_vld <= 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 7'd1;
            2'b01:   r_level <= r_level - 7'd1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Output data is latched on entry to ISSUE and held until the next one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_hcnt     <= '0;
         r_load_out <= 1'b0;
         r_out      <= '0;
      end else begin
         r_load_out <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if ((r_level != 7'd0) && gen_ready) begin
                  r_state    <= S_ISSUE;
                  r_load_out <= 1'b1;
                  r_out      <= r_mem[r_rd_ptr];
               end
            end
            S_ISSUE: begin
               r_state <= S_HOLD;
               r_hcnt  <= '0;
            end
            S_HOLD: begin
               if (r_hcnt == 4'(HOLDOFF - 1)) begin
                  r_state <= S_WAIT;
               end else begin
                  r_hcnt <= r_hcnt + 4'd1;
               end
            end
            default: begin
               if (gen_ready) begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_drop  <= '0;
         r_dup   <= '0;
         r_inval <= '0;
      end else if (clear_counters) begin
         r_drop  <= '0;
         r_dup   <= '0;
         r_inval <= '0;
      end else begin
         if (w_drop && (r_drop != 16'hFFFF)) begin
            r_drop <= r_drop + 16'd1;
         end
         if (w_dup && (r_dup != 16'hFFFF)) begin
            r_dup <= r_dup + 16'd1;
         end
         if (w_inval && (r_inval != 16'hFFFF)) begin
            r_inval <= r_inval + 16'd1;
         end
      end
   end

   assign load_out    = r_load_out;
   assign bcid_out    = r_out[24:13];
   assign band_id_out = r_out[12:5];
   assign phi_id_out  = r_out[4:0];
   assign fifo_level  = r_level;
   assign drop_count  = r_drop;
   assign dup_count   = r_dup;
   assign inval_count = r_inval;

endmodule

// File: tb/tb_strip_trigger_queue.sv
// Randomised bench for strip_trigger_queue with a queue-based
// reference model and a scoreboard of predicted issues.
module tb_strip_trigger_queue;

   localparam int DEPTH = 8;
   localparam int H     = 3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        load_in = 1'b0;
   logic [11:0] bcid_in = '0;
   logic [7:0]  band_id_in = '0;
   logic [4:0]  phi_id_in = 5'h0B;
   logic        gen_ready = 1'b0;
   logic        clear_counters = 1'b0;
   logic        load_out;
   logic [11:0] bcid_out;
   logic [7:0]  band_id_out;
   logic [4:0]  phi_id_out;
   logic [6:0]  fifo_level;
   logic [15:0] drop_count;
   logic [15:0] dup_count;
   logic [15:0] inval_count;

   always #3 clk = ~clk;

   strip_trigger_queue #(.DEPTH(DEPTH), .HOLDOFF(H)) dut (
      .clk(clk), .reset_n(reset_n), .load_in(load_in),
      .bcid_in(bcid_in), .band_id_in(band_id_in),
      .phi_id_in(phi_id_in), .gen_ready(gen_ready),
      .clear_counters(clear_counters), .load_out(load_out),
      .bcid_out(bcid_out), .band_id_out(band_id_out),
      .phi_id_out(phi_id_out), .fifo_level(fifo_level),
      .drop_count(drop_count), .dup_count(dup_count),
      .inval_count(inval_count)
   );

   typedef struct {
      int          cyc;
      logic [24:0] d;
   } exp_t;

   exp_t        sb[$];
   logic [24:0] mq[$];
   int          cyc;
   int          m_issue_at;
   int          m_wait_start;
   bit          m_seen;
   logic [24:0] m_hold;
   int          m_drop, m_dup, m_inval;
   logic [19:0] m_last;
   bit          m_last_vld;
   int          checks = 0;
   int          errors = 0;
   int          last_issue;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: the FIFO is a queue, issue pacing is tracked as
   // cycle numbers (issue cycle, start of ready-wait, ready seen).
   initial begin
      cyc = 0;
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            sb.delete();
            mq.delete();
            m_issue_at   = -1;
            m_wait_start = 0;
            m_seen       = 1;
            m_hold       = '0;
            m_drop       = 0;
            m_dup        = 0;
            m_inval      = 0;
            m_last_vld   = 0;
            m_last       = '0;
         end else begin
            int lvl;
            bit is_issue;
            bit idle;
            lvl      = mq.size();
            is_issue = (cyc == m_issue_at);
            idle     = !is_issue && (cyc >= m_wait_start) && m_seen;
            if (idle && lvl > 0 && gen_ready) begin
               m_issue_at   = cyc + 1;
               m_wait_start = cyc + 2 + H;
               m_seen       = 0;
               m_hold       = mq[0];
               sb.push_back('{cyc + 1, mq[0]});
            end else if (cyc >= m_wait_start && gen_ready) begin
               m_seen = 1;
            end
            if (is_issue) void'(mq.pop_front());
            if (load_in) begin
               if (band_id_in == 8'hFF) begin
                  if (m_inval < 65535) m_inval++;
               end else if (m_last_vld &&
                            {bcid_in, band_id_in} == m_last) begin
                  if (m_dup < 65535) m_dup++;
               end else if (lvl == DEPTH) begin
                  if (m_drop < 65535) m_drop++;
               end else begin
                  mq.push_back({bcid_in, band_id_in, phi_id_in});
                  m_last     = {bcid_in, band_id_in};
                  m_last_vld = 1;
               end
            end
            if (clear_counters) begin
               m_drop  = 0;
               m_dup   = 0;
               m_inval = 0;
            end
            cyc++;
         end
      end
   end

   // Monitor: compares every cycle on the falling edge.
   initial begin
      last_issue = -1000;
      forever begin
         @(negedge clk);
         if (!reset_n) last_issue = -1000;
         check("fifo_level", int'(fifo_level), mq.size());
         check("drop_count", int'(drop_count), m_drop);
         check("dup_count", int'(dup_count), m_dup);
         check("inval_count", int'(inval_count), m_inval);
         check("out_data", int'({bcid_out, band_id_out, phi_id_out}),
               int'(m_hold));
         if (load_out) begin
            if (sb.size() == 0) begin
               check("spurious_load_out", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("issue_cycle", cyc, e.cyc);
               check("issue_data",
                     int'({bcid_out, band_id_out, phi_id_out}),
                     int'(e.d));
               check("issue_spacing_ok",
                     int'((cyc - last_issue) >= H + 3), 1);
            end
            last_issue = cyc;
         end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            check("missing_load_out", 0, 1);
            void'(sb.pop_front());
         end
      end
   end

   task automatic drv(bit ld, logic [11:0] b, logic [7:0] bd,
                      bit gr, bit clr);
      @(negedge clk);
      #1;
      load_in        = ld;
      bcid_in        = b;
      band_id_in     = bd;
      gen_ready      = gr;
      clear_counters = clr;
   endtask

   task automatic idle_n(int n, bit gr);
      for (int i = 0; i < n; i++) drv(0, 12'h0, 8'h0, gr, 0);
   endtask

   task automatic do_reset(int n);
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      load_in = 1'b0;
      repeat (n) @(negedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      reset_n = 1'b1;
      idle_n(2, 0);
      // single request, ready generator
      drv(1, 12'h123, 8'h2A, 1, 0);
      idle_n(10, 1);
      // overflow then drain in order
      for (int i = 0; i < 10; i++) drv(1, 12'h200 + 12'(i), 8'h10, 0, 0);
      idle_n(2, 0);
      idle_n(8 * (H + 3) + 20, 1);
      // duplicate and invalid filtering
      drv(1, 12'h005, 8'h07, 0, 0);
      drv(1, 12'h005, 8'h07, 0, 0);
      drv(1, 12'h005, 8'hFF, 0, 0);
      idle_n(2, 0);
      idle_n(20, 1);
      // push into a full FIFO in the pop cycle
      for (int i = 0; i < DEPTH; i++) drv(1, 12'h300 + 12'(i), 8'h20, 0, 0);
      drv(0, 12'h0, 8'h0, 1, 0);
      drv(1, 12'h3FF, 8'h21, 1, 0);
      idle_n(DEPTH * (H + 3) + 20, 1);
      // reset during holdoff with entries queued
      for (int i = 0; i < 3; i++) drv(1, 12'h400 + 12'(i), 8'h30, 0, 0);
      drv(0, 12'h0, 8'h0, 1, 0);
      drv(0, 12'h0, 8'h0, 1, 0);
      do_reset(2);
      idle_n(20, 1);
      // drop counter saturation, then clear against a drop
      for (int i = 0; i < DEPTH; i++) drv(1, 12'h500 + 12'(i), 8'h55, 0, 0);
      for (int i = 0; i < 65540; i++) drv(1, 12'(i), 8'h56, 0, 0);
      drv(1, 12'h7AA, 8'h56, 0, 0);
      drv(1, 12'h7AB, 8'h56, 0, 1);
      idle_n(2, 0);
      idle_n(DEPTH * (H + 3) + 20, 1);
      // randomised traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 999) == 0) begin
            do_reset($urandom_range(1, 3));
         end else begin
            logic [7:0] bd;
            bd = ($urandom_range(0, 7) == 0) ? 8'hFF
                 : 8'($urandom_range(0, 2));
            if ($urandom_range(0, 63) == 0) phi_id_in = 5'($urandom);
            drv($urandom_range(0, 1) == 1, 12'($urandom_range(0, 3)), bd,
                $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
         end
      end
      idle_n(DEPTH * (H + 3) + 40, 1);
      check("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
